// File: rtl/counter_prescaler_if.sv
// counter_prescaler_if: control/status bundle between a timer controller
// (master) and the prescaler (slave). WID sets divisor and counter width.
interface counter_prescaler_if #(
    parameter int WID = 16
);
    logic           en;
    logic [1:0]     mode;
    logic           ld;
    logic [WID:1]   div;
    logic           arm;
    logic           ext_evt;
    logic           ce_o;
    logic           busy;
    logic [WID:1]   q;

    modport master (
        output en, mode, ld, div, arm, ext_evt,
        input  ce_o, busy, q
    );

    modport slave (
        input  en, mode, ld, div, arm, ext_evt,
        output ce_o, busy, q
    );
endinterface

// File: rtl/counter_prescaler.sv
// counter_prescaler: divides clk or ext_evt edges by (div+1) and emits a
// one-clk clock-enable pulse (ce_o) for a downstream counter. Supports
// free-running and armed one-shot operation.
// Optional macro PRESCALER_EXT_SYNC_EN: adds a 2-flop synchronizer on ext_evt
// (ext_evt may then be asynchronous; edge-to-ce_o latency becomes 3 clk).
module counter_prescaler #(
    parameter int WID = 16
) (
    input  logic               clk,
    input  logic               rst,
    counter_prescaler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] MODE_CLK   = 2'b00;
    localparam logic [1:0] MODE_RISE  = 2'b01;
    localparam logic [1:0] MODE_FALL  = 2'b10;
    localparam logic [1:0] MODE_SHOT  = 2'b11;

    state_t         state;
    logic [WID:1]   div_r;
    logic [WID:1]   q_r;
    logic           ce_r;
    logic           busy_r;
    logic           s;
    logic           s_prev;
    logic           evt;

`ifdef PRESCALER_EXT_SYNC_EN
    logic           sync1;
    logic           sync2;

    // Two-flop synchronizer so ext_evt may come from another clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.ext_evt;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = bus.ext_evt;
`endif

    // Edge history for rising/falling event detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) s_prev <= 1'b0;
        else      s_prev <= s;
    end

    // Event qualifier: clk modes count every cycle, ext modes count edges.
    always_comb begin
        evt = 1'b1;
        case (bus.mode)
            MODE_RISE: evt = s & ~s_prev;
            MODE_FALL: evt = ~s & s_prev;
            default:   evt = 1'b1;
        endcase
    end

    // Control FSM with down-counter; ce_o and busy are registered here so
    // busy always tracks the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            div_r  <= '0;
            q_r    <= '0;
            ce_r   <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            ce_r <= 1'b0;
            if (!bus.en) begin
                // Disable wins over everything except the divisor load.
                state  <= IDLE;
                busy_r <= 1'b0;
                if (bus.ld) begin
                    div_r <= bus.div;
                    q_r   <= bus.div;
                end else begin
                    q_r   <= div_r;
                end
            end else if (bus.ld) begin
                // Load suppresses any tick this cycle and holds the state.
                div_r <= bus.div;
                q_r   <= bus.div;
            end else begin
                case (state)
                    IDLE: begin
                        q_r <= div_r;
                        if (bus.mode != MODE_SHOT || bus.arm) begin
                            state  <= RUN;
                            busy_r <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (evt) begin
                            if (q_r == '0) begin
                                q_r  <= div_r;
                                ce_r <= 1'b1;
                                if (bus.mode == MODE_SHOT) begin
                                    state  <= DONE;
                                    busy_r <= 1'b0;
                                end
                            end else begin
                                q_r <= q_r - 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        q_r <= div_r;
                        if (bus.arm || bus.mode != MODE_SHOT) begin
                            state  <= RUN;
                            busy_r <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ce_o = ce_r;
    assign bus.busy = busy_r;
    assign bus.q    = q_r;

endmodule

// File: tb/tb_counter_prescaler.sv
// tb_counter_prescaler: directed scoreboard bench. Each step pushes the
// outputs expected after the next rising edge; a monitor pops and compares.
module tb_counter_prescaler;
    localparam int WID = 16;
`ifdef PRESCALER_EXT_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    typedef struct {
        string tag;
        logic  ce;
        logic  busy;
        int    q;
        bit    cq;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    exp_t sb[$];
    exp_t e;

    counter_prescaler_if #(.WID(WID)) bus ();

    counter_prescaler #(.WID(WID)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step(input string tag, input logic ece, input logic ebusy,
                        input int eq, input bit cq = 1'b1);
        exp_t x;
        x.tag = tag; x.ce = ece; x.busy = ebusy; x.q = eq; x.cq = cq;
        sb.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: compare just after each active edge.
    always begin
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, ".ce"},   {31'd0, bus.ce_o}, {31'd0, e.ce});
            chk({e.tag, ".busy"}, {31'd0, bus.busy}, {31'd0, e.busy});
            if (e.cq) chk({e.tag, ".q"}, {16'd0, bus.q}, e.q);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.mode = 2'b00; bus.ld = 1'b0; bus.div = '0;
        bus.arm = 1'b0; bus.ext_evt = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.ce",   {31'd0, bus.ce_o}, 0);
        chk("rst.busy", {31'd0, bus.busy}, 0);
        chk("rst.q",    {16'd0, bus.q},    0);
        rst_n = 1'b1;

        // Mode 00, div=2: q 2,1,0 then tick with reload.
        bus.ld = 1'b1; bus.div = 16'd2;
        step("m0.ld", 0, 0, 2);
        bus.ld = 1'b0; bus.en = 1'b1;
        step("m0.go", 0, 1, 2);
        step("m0.c1", 0, 1, 1);
        step("m0.c2", 0, 1, 0);
        step("m0.t1", 1, 1, 2);
        step("m0.c4", 0, 1, 1);
        step("m0.c5", 0, 1, 0);
        step("m0.t2", 1, 1, 2);

        // div=0: ce_o continuous from 2nd RUN cycle.
        bus.en = 1'b0; bus.ld = 1'b1; bus.div = 16'd0;
        step("d0.ld", 0, 0, 0);
        bus.en = 1'b1; bus.ld = 1'b0;
        step("d0.go", 0, 1, 0);
        for (int i = 0; i < 4; i++) step("d0.on", 1, 1, 0);

        // ld collides with a tick: no ce_o, q loads 7.
        bus.ld = 1'b1; bus.div = 16'd7;
        step("ldc", 0, 1, 7);
        bus.ld = 1'b0;
        for (int i = 6; i >= 1; i--) step("ldc.dn", 0, 1, i);

        // en drop at q=1: no tick, reload to div_r.
        bus.en = 1'b0;
        step("endrop", 0, 0, 7);
        step("endrop2", 0, 0, 7);

        // Mode 11 one-shot, div=3.
        bus.ld = 1'b1; bus.div = 16'd3;
        step("os.ld", 0, 0, 3);
        bus.ld = 1'b0; bus.en = 1'b1; bus.mode = 2'b11;
        step("os.noarm", 0, 0, 3);
        bus.arm = 1'b1;
        step("os.arm", 0, 1, 3);
        bus.arm = 1'b0;
        step("os.c1", 0, 1, 2);
        step("os.c2", 0, 1, 1);
        step("os.c3", 0, 1, 0);
        step("os.tick", 1, 0, 3);
        step("os.done", 0, 0, 3);
        step("os.done2", 0, 0, 3);
        // Re-arm, holding arm through RUN: it must not retrigger.
        bus.arm = 1'b1;
        step("os2.arm", 0, 1, 3);
        step("os2.c1", 0, 1, 2);
        step("os2.c2", 0, 1, 1);
        step("os2.c3", 0, 1, 0);
        step("os2.tick", 1, 0, 3);
        bus.arm = 1'b0;
        step("os2.done", 0, 0, 3);

        // Mode 01, div=1: ext_evt toggles every 4 clk.
        bus.en = 1'b0; bus.ld = 1'b1; bus.div = 16'd1; bus.mode = 2'b01;
        step("r.ld", 0, 0, 1);
        bus.ld = 1'b0; bus.en = 1'b1;
        step("r.go", 0, 1, 1);
        for (int t = 0; t < 36; t++) begin
            bus.ext_evt = ((t >> 2) & 1) != 0;
            step("rise", ((t - D) == 12) || ((t - D) == 28), 1, 0, 1'b0);
        end

        // Mode 10, same divisor.
        bus.en = 1'b0; bus.mode = 2'b10;
        step("f.idle", 0, 0, 1);
        bus.en = 1'b1;
        step("f.go", 0, 1, 1);
        for (int t = 0; t < 36; t++) begin
            bus.ext_evt = ((t >> 2) & 1) != 0;
            step("fall", ((t - D) == 16) || ((t - D) == 32), 1, 0, 1'b0);
        end

        // Asynchronous reset mid-count at q=5.
        bus.en = 1'b0; bus.mode = 2'b00; bus.ld = 1'b1; bus.div = 16'd7;
        step("ar.ld", 0, 0, 7);
        bus.ld = 1'b0; bus.en = 1'b1;
        step("ar.go", 0, 1, 7);
        step("ar.c1", 0, 1, 6);
        step("ar.c2", 0, 1, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.ce",   {31'd0, bus.ce_o}, 0);
        chk("ar.busy", {31'd0, bus.busy}, 0);
        chk("ar.q",    {16'd0, bus.q},    0);
        @(negedge clk);
        bus.en = 1'b0;
        rst_n = 1'b1;
        step("ar.idle1", 0, 0, 0);
        step("ar.idle2", 0, 0, 0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
